// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch stage: next-PC select codes,
// fetch FSM states and the word substituted for a timed-out fetch.
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_JR  = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } fetch_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC mux: sequential +4, branch target, J-type jump
// built from the current IR and PC region, or register jump.
module pc_next_sel
  import fetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [1:0]  sel,
  input  logic [31:0] br_target,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc_next
);

  always_comb begin
    pc_next = pc + 32'd4;
    case (pc_sel_e'(sel))
      PC_SEQ:  pc_next = pc + 32'd4;
      PC_BR:   pc_next = br_target;
      PC_JMP:  pc_next = {pc[31:28], ir[25:0], 2'b00};
      PC_JR:   pc_next = jr_addr;
      default: pc_next = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC register, memory request handshake with
// timeout, instruction register and the IR field decode for Control.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for IR_W; MEM_ADDR holds the last fetch address
// ST_REQ  | MEM_REQ high, waiting for MEM_VALID or the wait budget
// ST_DONE | IR holds the fetched word, IR_VALID pulse
// ST_ERR  | fetch timed out, IR holds NOP, FETCH_ERR pulse
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_LD,
  input  logic [1:0]  SEL_PC,
  input  logic        IR_W,
  input  logic [31:0] BR_TARGET,
  input  logic [31:0] JR_ADDR,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_VALID,
  output logic        MEM_REQ,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] PC,
  output logic [31:0] IR,
  output logic [5:0]  OPCODE,
  output logic [4:0]  RS,
  output logic [4:0]  RT,
  output logic [4:0]  RD,
  output logic [5:0]  FUNCT,
  output logic [15:0] IMM,
  output logic        FETCH_BUSY,
  output logic        IR_VALID,
  output logic        FETCH_ERR
);

  // Wait timer counts down from MAX_WAIT-1; terminal count is zero.
  localparam logic [7:0] WAIT_LOAD = 8'(MAX_WAIT - 1);

  fetch_state_e state, state_nxt;
  logic [7:0]   wait_cnt, wait_cnt_nxt;
  logic [31:0]  pc_q, pc_next;
  logic [31:0]  ir_q, ir_nxt;
  logic [31:0]  addr_q, addr_nxt;

  pc_next_sel u_pc_next_sel (
    .pc        (pc_q),
    .ir        (ir_q),
    .sel       (SEL_PC),
    .br_target (BR_TARGET),
    .jr_addr   (JR_ADDR),
    .pc_next   (pc_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 8'd0;
      pc_q     <= RESET_PC;
      ir_q     <= NOP_WORD;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      ir_q     <= ir_nxt;
      addr_q   <= addr_nxt;
      if (PC_LD) pc_q <= pc_next;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ir_nxt       = ir_q;
    addr_nxt     = addr_q;
    case (state)
      ST_IDLE: begin
        if (IR_W) begin
          addr_nxt     = pc_q;
          wait_cnt_nxt = WAIT_LOAD;
          state_nxt    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (MEM_VALID) begin
          ir_nxt    = MEM_RDATA;
          state_nxt = ST_DONE;
        end else if (wait_cnt == 8'd0) begin
          ir_nxt    = NOP_WORD;
          state_nxt = ST_ERR;
        end else begin
          wait_cnt_nxt = wait_cnt - 8'd1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign MEM_REQ    = (state == ST_REQ);
  assign FETCH_BUSY = (state == ST_REQ);
  assign IR_VALID   = (state == ST_DONE);
  assign FETCH_ERR  = (state == ST_ERR);
  assign MEM_ADDR   = addr_q;
  assign PC         = pc_q;
  assign IR         = ir_q;
  assign OPCODE     = ir_q[31:26];
  assign RS         = ir_q[25:21];
  assign RT         = ir_q[20:16];
  assign RD         = ir_q[15:11];
  assign FUNCT      = ir_q[5:0];
  assign IMM        = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed corner sequences, a next-PC
// vector table and randomized fetches against a transaction-level model.
module tb_instr_fetch;

  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        PC_LD;
  logic [1:0]  SEL_PC;
  logic        IR_W;
  logic [31:0] BR_TARGET, JR_ADDR, MEM_RDATA;
  logic        MEM_VALID;
  logic        MEM_REQ;
  logic [31:0] MEM_ADDR, PC, IR;
  logic [5:0]  OPCODE, FUNCT;
  logic [4:0]  RS, RT, RD;
  logic [15:0] IMM;
  logic        FETCH_BUSY, IR_VALID, FETCH_ERR;

  int checks = 0;
  int errors = 0;

  logic [31:0] mpc, mir;

  instr_fetch #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .PC_LD(PC_LD), .SEL_PC(SEL_PC), .IR_W(IR_W),
    .BR_TARGET(BR_TARGET), .JR_ADDR(JR_ADDR), .MEM_RDATA(MEM_RDATA),
    .MEM_VALID(MEM_VALID), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .PC(PC),
    .IR(IR), .OPCODE(OPCODE), .RS(RS), .RT(RT), .RD(RD), .FUNCT(FUNCT),
    .IMM(IMM), .FETCH_BUSY(FETCH_BUSY), .IR_VALID(IR_VALID),
    .FETCH_ERR(FETCH_ERR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] pc0;
    logic [31:0] br;
    logic [31:0] jr;
    logic [31:0] exp_pc;
  } pc_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_next(input logic [1:0] s, input logic [31:0] pc,
                                           input logic [31:0] ir, input logic [31:0] br,
                                           input logic [31:0] jr);
    case (s)
      2'd0:    return pc + 32'd4;
      2'd1:    return br;
      2'd2:    return (pc & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) << 2);
      default: return jr;
    endcase
  endfunction

  task automatic rand_pc_in();
    PC_LD     = 1'($urandom_range(0, 1));
    SEL_PC    = 2'($urandom_range(0, 3));
    BR_TARGET = $urandom;
    JR_ADDR   = $urandom;
  endtask

  task automatic step_model();
    if (PC_LD) mpc = ref_next(SEL_PC, mpc, mir, BR_TARGET, JR_ADDR);
    step();
  endtask

  task automatic load_pc(input logic [31:0] v);
    PC_LD = 1'b1; SEL_PC = 2'd3; JR_ADDR = v;
    step();
    PC_LD = 1'b0;
  endtask

  task automatic quick_fetch(input logic [31:0] word);
    IR_W = 1'b1;
    step();
    IR_W = 1'b0; MEM_VALID = 1'b1; MEM_RDATA = word;
    step();
    MEM_VALID = 1'b0;
    chk("quick_fetch_ir", IR, word);
    step();
  endtask

  pc_vec_t vecs[6];

  initial begin
    int req_cycles;
    logic [31:0] exp_addr, data;
    int d;
    logic got_valid, done;

    vecs[0] = '{2'd0, 32'h0000_0010, 32'h0,  32'h0,  32'h0000_0014};
    vecs[1] = '{2'd1, 32'h0000_0010, 32'h40, 32'h0,  32'h0000_0040};
    vecs[2] = '{2'd2, 32'h0000_0010, 32'h0,  32'h0,  32'h0000_0400};
    vecs[3] = '{2'd3, 32'h0000_0010, 32'h0,  32'h80, 32'h0000_0080};
    vecs[4] = '{2'd0, 32'hFFFF_FFFC, 32'h0,  32'h0,  32'h0000_0000};
    vecs[5] = '{2'd2, 32'hA000_0010, 32'h0,  32'h0,  32'hA000_0400};

    reset = 1'b0; IR_W = 1'b1; PC_LD = 1'b0; SEL_PC = 2'd0;
    BR_TARGET = 32'h0; JR_ADDR = 32'h0; MEM_RDATA = 32'h0; MEM_VALID = 1'b0;

    // Reset held with IR_W high: nothing may start.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_pc", PC, 32'h0);
      chk("rst_mem_req", MEM_REQ, 1'b0);
      chk("rst_ir", IR, 32'h0);
      chk("rst_mem_addr", MEM_ADDR, 32'h0);
      chk("rst_strobes", {FETCH_BUSY, IR_VALID, FETCH_ERR}, 3'b000);
    end
    reset = 1'b1;
    step();
    chk("post_rst_req", MEM_REQ, 1'b1);
    chk("post_rst_busy", FETCH_BUSY, 1'b1);
    IR_W = 1'b0; MEM_VALID = 1'b1; MEM_RDATA = 32'h5022_0004;
    step();
    MEM_VALID = 1'b0;
    chk("fast_ir_valid", IR_VALID, 1'b1);
    chk("fast_opcode", OPCODE, 6'd20);
    chk("fast_imm", IMM, 16'd4);
    chk("fast_rs_rt", {RS, RT}, {5'd1, 5'd2});
    chk("fast_req_drop", MEM_REQ, 1'b0);
    step();
    chk("fast_ir_valid_pulse", IR_VALID, 1'b0);

    // Valid delayed three cycles; stray IR_W and PC change during REQ.
    IR_W = 1'b1;
    step();
    IR_W = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("slow_req", MEM_REQ, 1'b1);
      chk("slow_addr", MEM_ADDR, 32'h0000_0004 - 32'h4);
      IR_W  = (c == 1);
      PC_LD = (c == 1); SEL_PC = 2'd3; JR_ADDR = 32'h0000_0100;
      MEM_VALID = (c == 3); MEM_RDATA = 32'hDEAD_BEEF;
      step();
    end
    IR_W = 1'b0; PC_LD = 1'b0; MEM_VALID = 1'b0;
    chk("slow_ir_valid", IR_VALID, 1'b1);
    chk("slow_ir", IR, 32'hDEAD_BEEF);
    chk("slow_pc", PC, 32'h0000_0100);
    step();
    chk("slow_idle", {MEM_REQ, IR_VALID}, 2'b00);
    step();
    chk("slow_no_queue", MEM_REQ, 1'b0);

    // Timeout: no MEM_VALID at all.
    IR_W = 1'b1;
    step();
    IR_W = 1'b0;
    req_cycles = 0;
    for (int c = 0; c < 40 && MEM_REQ; c++) begin
      req_cycles++;
      step();
    end
    chk("to_req_cycles", req_cycles, MW);
    chk("to_fetch_err", FETCH_ERR, 1'b1);
    chk("to_ir_nop", IR, 32'h0);
    step();
    chk("to_err_pulse", FETCH_ERR, 1'b0);

    // Next-PC vector table with IR = 0x0800_0100.
    quick_fetch(32'h0800_0100);
    foreach (vecs[i]) begin
      load_pc(vecs[i].pc0);
      PC_LD = 1'b1; SEL_PC = vecs[i].sel;
      BR_TARGET = vecs[i].br; JR_ADDR = vecs[i].jr;
      step();
      PC_LD = 1'b0;
      chk($sformatf("pc_vec%0d", i), PC, vecs[i].exp_pc);
    end

    // IR_W and PC_LD together, then reset in the middle of the request.
    load_pc(32'h0000_0020);
    IR_W = 1'b1; PC_LD = 1'b1; SEL_PC = 2'd0;
    step();
    IR_W = 1'b0; PC_LD = 1'b0;
    chk("same_cyc_addr", MEM_ADDR, 32'h0000_0020);
    chk("same_cyc_pc", PC, 32'h0000_0024);
    chk("same_cyc_req", MEM_REQ, 1'b1);
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("midrst_req", MEM_REQ, 1'b0);
    chk("midrst_pc", PC, 32'h0);
    chk("midrst_addr", MEM_ADDR, 32'h0);
    chk("midrst_ir", IR, 32'h0);
    MEM_VALID = 1'b1; MEM_RDATA = 32'h1234_5678;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("midrst_valid_ignored", {IR, IR_VALID, MEM_REQ}, {32'h0, 1'b0, 1'b0});
    end
    MEM_VALID = 1'b0;

    // Randomized fetches against the transaction model.
    mpc = 32'h0; mir = 32'h0;
    for (int t = 0; t < 60; t++) begin
      IR_W = 1'b1; MEM_VALID = 1'($urandom_range(0, 1)); MEM_RDATA = $urandom;
      rand_pc_in();
      exp_addr = mpc;
      step_model();
      d = $urandom_range(0, MW + 2);
      got_valid = 1'b0; done = 1'b0;
      for (int c = 0; c < MW && !done; c++) begin
        chk("rnd_req", MEM_REQ, 1'b1);
        chk("rnd_addr", MEM_ADDR, exp_addr);
        chk("rnd_pc", PC, mpc);
        IR_W = 1'($urandom_range(0, 1));
        MEM_VALID = (c == d); MEM_RDATA = $urandom; data = MEM_RDATA;
        rand_pc_in();
        step_model();
        if (c == d) begin
          mir = data; got_valid = 1'b1; done = 1'b1;
        end else if (c == MW - 1) begin
          mir = 32'h0; done = 1'b1;
        end
      end
      chk("rnd_outcome", {IR_VALID, FETCH_ERR}, got_valid ? 2'b10 : 2'b01);
      chk("rnd_ir", IR, mir);
      chk("rnd_req_drop", MEM_REQ, 1'b0);
      chk("rnd_pc_end", PC, mpc);
      IR_W = 1'($urandom_range(0, 1)); MEM_VALID = 1'($urandom_range(0, 1));
      rand_pc_in();
      step_model();
      IR_W = 1'b0; MEM_VALID = 1'b0; PC_LD = 1'b0;
      chk("rnd_idle", {IR_VALID, FETCH_ERR, MEM_REQ}, 3'b000);
      chk("rnd_ir_hold", IR, mir);
      chk("rnd_pc_idle", PC, mpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
